// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the instruction
// fetch port and the data port of the core. Data has priority; a starvation
// counter forces a fetch grant after STARVE consecutive data grants while a
// fetch is waiting. In-flight fetches can be aborted; the memory access still
// completes so the memory handshake is never left dangling.
// Optional build macro ARB_STATS_EN adds four 32-bit event counters read
// through stat_sel/stat_out.
module mem_port_arbiter #(
    parameter int N      = 64,
    parameter int AW     = 32,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_adr,
    input  logic          i_abort,
    output logic          i_hit,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic [1:0]    d_we,
    input  logic [AW-1:0] d_adr,
    input  logic [N-1:0]  d_wdata,
    output logic          d_ready,
    output logic [N-1:0]  d_rdata,
    output logic          m_req,
    output logic [1:0]    m_we,
    output logic [AW-1:0] m_adr,
    output logic [N-1:0]  m_wdata,
    input  logic [N-1:0]  m_rdata,
`ifdef ARB_STATS_EN
    input  logic [1:0]    stat_sel,
    output logic [31:0]   stat_out,
`endif
    input  logic          m_ack
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam int            CW         = $clog2(STARVE + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE);

    logic [1:0]    state;
    logic          abort_flag;
    logic [CW-1:0] starve_cnt;

    logic fetch_ok;
    logic force_fetch;
    logic grant_d;
    logic grant_i;
    logic fetch_aborted;

    // Grant decision in IDLE and detection of an aborted fetch completing
    always_comb begin
        fetch_ok      = i_req && !i_abort;
        force_fetch   = fetch_ok && (starve_cnt == STARVE_MAX);
        grant_d       = (state == IDLE) && d_req && !force_fetch;
        grant_i       = (state == IDLE) && fetch_ok && !grant_d;
        // An abort arriving in the same cycle as m_ack also cancels the hit
        fetch_aborted = (state == BUSY_I) && m_ack && (abort_flag || i_abort);
    end

    // Starvation counter: counts data grants that overtook a waiting fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!i_req || grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    // Arbiter FSM with registered memory request and requester responses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            abort_flag <= 1'b0;
            m_req      <= 1'b0;
            m_we       <= 2'b00;
            m_adr      <= '0;
            m_wdata    <= '0;
            i_hit      <= 1'b0;
            i_rdata    <= '0;
            d_ready    <= 1'b0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_adr   <= d_adr;
                        m_wdata <= d_wdata;
                        state   <= BUSY_D;
                    end else if (grant_i) begin
                        m_req <= 1'b1;
                        m_we  <= 2'b00;
                        m_adr <= i_adr;
                        state <= BUSY_I;
                    end
                end
                BUSY_I: begin
                    if (m_ack) begin
                        m_req      <= 1'b0;
                        abort_flag <= 1'b0;
                        if (fetch_aborted) begin
                            state <= IDLE;
                        end else begin
                            i_rdata <= m_rdata[31:0];
                            i_hit   <= 1'b1;
                            state   <= RESP;
                        end
                    end else if (i_abort) begin
                        abort_flag <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (m_ack) begin
                        m_req   <= 1'b0;
                        d_rdata <= m_rdata;
                        d_ready <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    // Response is committed; a late abort does not retract it
                    i_hit   <= 1'b0;
                    d_ready <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] stat_cnt [4];
    logic        stall;

    // Fetch stall: fetch waiting while the memory is busy or data took it
    always_comb begin
        stall = i_req && ((state != IDLE) || grant_d);
    end

    // Free-running wrapping event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                stat_cnt[k] <= '0;
            end
        end else begin
            if (grant_i)       stat_cnt[0] <= stat_cnt[0] + 32'd1;
            if (grant_d)       stat_cnt[1] <= stat_cnt[1] + 32'd1;
            if (fetch_aborted) stat_cnt[2] <= stat_cnt[2] + 32'd1;
            if (stall)         stat_cnt[3] <= stat_cnt[3] + 32'd1;
        end
    end

    // Counter readback
    always_comb begin
        stat_out = stat_cnt[stat_sel];
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks for mem_port_arbiter,
// with a behavioural memory and a cycle-timeline reference of the arbiter.
module tb_mem_port_arbiter;
    localparam int N      = 64;
    localparam int AW     = 32;
    localparam int STARVE = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_adr;
    logic          i_abort;
    logic          i_hit;
    logic [31:0]   i_rdata;
    logic          d_req;
    logic [1:0]    d_we;
    logic [AW-1:0] d_adr;
    logic [N-1:0]  d_wdata;
    logic          d_ready;
    logic [N-1:0]  d_rdata;
    logic          m_req;
    logic [1:0]    m_we;
    logic [AW-1:0] m_adr;
    logic [N-1:0]  m_wdata;
    logic [N-1:0]  m_rdata = '0;
    logic          m_ack = 1'b0;
`ifdef ARB_STATS_EN
    logic [1:0]    stat_sel;
    logic [31:0]   stat_out;
`endif

    mem_port_arbiter #(.N(N), .AW(AW), .STARVE(STARVE)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_adr(i_adr), .i_abort(i_abort),
        .i_hit(i_hit), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata),
        .m_rdata(m_rdata),
`ifdef ARB_STATS_EN
        .stat_sel(stat_sel), .stat_out(stat_out),
`endif
        .m_ack(m_ack)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;

    // Memory environment: acks after mem_lat cycles of m_req, read-modify-write
    int          mem_lat   = 1;
    int          stray_req = 0;
    int          stray_done = 0;
    int          lat_cnt   = 0;
    bit          mem_init  = 1'b0;
    logic [63:0] bmem [256];
    logic [63:0] mw;

    function automatic logic [63:0] init_word(input int i);
        if (i == 8) return 64'h1234_5678_8C08_0004;
        return {(32'(i) * 32'h0101_0101) ^ 32'hA500_0000, ~32'(i) ^ 32'h00C3_0000};
    endfunction

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) bmem[i] = init_word(i);
            mem_init = 1'b1;
        end
        if (m_ack) begin
            m_ack = 1'b0;
        end else if (stray_done != stray_req) begin
            stray_done = stray_req;
            m_rdata    = 64'hBADD_F00D_BADD_F00D;
            m_ack      = 1'b1;
        end else if (m_req) begin
            lat_cnt++;
            if (lat_cnt >= mem_lat) begin
                mw = bmem[m_adr[10:3]];
                if (m_we[0]) mw[31:0]  = m_wdata[31:0];
                if (m_we[1]) mw[63:32] = m_wdata[63:32];
                bmem[m_adr[10:3]] = mw;
                m_rdata = mw;
                m_ack   = 1'b1;
                lat_cnt = 0;
            end
        end else begin
            lat_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

`ifdef ARB_STATS_EN
    // One complete transaction with memory latency 2, optionally aborted
    task automatic do_txn(input bit f, input bit ab);
        mem_lat = 2;
        if (f) begin i_req = 1'b1; i_adr = 32'h440; end
        else begin d_req = 1'b1; d_we = 2'b00; d_adr = 32'h440; end
        next_cycle();
        if (ab) begin i_abort = 1'b1; i_req = 1'b0; end
        next_cycle();
        i_abort = 1'b0;
        next_cycle();
        next_cycle();
        i_req = 1'b0;
        d_req = 1'b0;
        next_cycle();
    endtask
`endif

    // Reference state for the randomized phase
    logic [63:0] smem [256];
    bit          busy, who_f, pulse, exp_mreq, gf, gd;
    int          g, lat, mcnt, done;
    logic [31:0] cur_adr;
    logic [1:0]  cur_we;
    logic [63:0] cur_wd, cur_rd, tmp;
    bit          f_act, d_act;
    int          f_gap, d_gap;
    logic [31:0] f_adr, d_adr_r;
    logic [1:0]  d_we_r;
    logic [63:0] d_wd_r;

    initial begin
        reset = 1'b1; i_req = 1'b0; i_adr = '0; i_abort = 1'b0;
        d_req = 1'b0; d_we = 2'b00; d_adr = '0; d_wdata = '0;
`ifdef ARB_STATS_EN
        stat_sel = 2'd0;
`endif
        for (int i = 0; i < 256; i++) smem[i] = init_word(i);

        // Reset state
        next_cycle(); next_cycle();
        @(negedge clk);
        chk("rst_mreq", 64'(m_req), 64'd0);
        chk("rst_ihit", 64'(i_hit), 64'd0);
        chk("rst_dready", 64'(d_ready), 64'd0);
        chk("rst_irdata", 64'(i_rdata), 64'd0);
        chk("rst_madr", 64'(m_adr), 64'd0);
        next_cycle(); reset = 1'b0;
        next_cycle();

        // Single fetch, memory acks on third m_req cycle
        mem_lat = 3; i_req = 1'b1; i_adr = 32'h40;
        @(negedge clk); chk("f_t0_mreq", 64'(m_req), 64'd0);
        next_cycle(); @(negedge clk);
        chk("f_t1_mreq", 64'(m_req), 64'd1);
        chk("f_t1_mwe", 64'(m_we), 64'd0);
        chk("f_t1_madr", 64'(m_adr), 64'h40);
        next_cycle(); @(negedge clk); chk("f_t2_ihit", 64'(i_hit), 64'd0);
        next_cycle(); @(negedge clk); chk("f_t3_ihit", 64'(i_hit), 64'd0);
        next_cycle(); @(negedge clk);
        chk("f_t4_ihit", 64'(i_hit), 64'd1);
        chk("f_t4_irdata", 64'(i_rdata), 64'h8C08_0004);
        chk("f_t4_mreq", 64'(m_req), 64'd0);
        next_cycle(); i_req = 1'b0; @(negedge clk);
        chk("f_t5_ihit", 64'(i_hit), 64'd0);
        chk("f_t5_mreq", 64'(m_req), 64'd0);
        next_cycle();

        // Simultaneous requests: data first, then fetch
        mem_lat = 1; d_req = 1'b1; d_we = 2'b11; d_adr = 32'h80;
        d_wdata = 64'hDEAD_BEEF_00C0_FFEE; i_req = 1'b1; i_adr = 32'h48;
        next_cycle(); @(negedge clk);
        chk("dp_mwe", 64'(m_we), 64'h3);
        chk("dp_madr", 64'(m_adr), 64'h80);
        chk("dp_mwdata", m_wdata, 64'hDEAD_BEEF_00C0_FFEE);
        next_cycle(); @(negedge clk);
        chk("dp_dready", 64'(d_ready), 64'd1);
        chk("dp_drdata", d_rdata, 64'hDEAD_BEEF_00C0_FFEE);
        chk("dp_ihit0", 64'(i_hit), 64'd0);
        next_cycle(); d_req = 1'b0; @(negedge clk);
        chk("dp_idle_mreq", 64'(m_req), 64'd0);
        next_cycle(); @(negedge clk);
        chk("dp_f_mreq", 64'(m_req), 64'd1);
        chk("dp_f_madr", 64'(m_adr), 64'h48);
        chk("dp_f_mwe", 64'(m_we), 64'd0);
        next_cycle(); @(negedge clk);
        tmp = init_word(9);
        chk("dp_f_ihit", 64'(i_hit), 64'd1);
        // A late abort during the response does not retract the hit
        i_abort = 1'b1;
        chk("dp_f_irdata", 64'(i_rdata), 64'(tmp[31:0]));
        next_cycle(); i_req = 1'b0; i_abort = 1'b0; @(negedge clk);
        chk("dp_f_ihit_end", 64'(i_hit), 64'd0);
        next_cycle();

        // Starvation guard: four data grants, one fetch, data resumes
        d_req = 1'b1; d_we = 2'b00; d_adr = 32'h400; i_req = 1'b1; i_adr = 32'h100;
        begin
            int j;
            j = 0;
            for (int k = 0; k < 6; k++) begin
                next_cycle(); @(negedge clk);
                chk($sformatf("sv_mreq%0d", k), 64'(m_req), 64'd1);
                chk($sformatf("sv_madr%0d", k), 64'(m_adr),
                    (k == 4) ? 64'h100 : 64'(32'h400 + 32'(8 * j)));
                next_cycle(); @(negedge clk);
                chk($sformatf("sv_ihit%0d", k), 64'(i_hit), (k == 4) ? 64'd1 : 64'd0);
                chk($sformatf("sv_dready%0d", k), 64'(d_ready), (k == 4) ? 64'd0 : 64'd1);
                next_cycle();
                if (k == 4) i_req = 1'b0;
                else begin j++; d_adr = 32'h400 + 32'(8 * j); end
                if (k == 5) d_req = 1'b0;
            end
        end
        @(negedge clk); chk("sv_end_mreq", 64'(m_req), 64'd0);
        next_cycle();

        // Abort in IDLE blocks the grant, then abort of an in-flight fetch
        mem_lat = 4; i_req = 1'b1; i_adr = 32'h60; i_abort = 1'b1;
        @(negedge clk);
        next_cycle(); i_abort = 1'b0; @(negedge clk);
        chk("ab_idle_mreq", 64'(m_req), 64'd0);
        next_cycle();
        i_abort = 1'b1; i_req = 1'b0; d_req = 1'b1; d_we = 2'b00; d_adr = 32'h408;
        @(negedge clk);
        chk("ab_g1_mreq", 64'(m_req), 64'd1);
        chk("ab_g1_madr", 64'(m_adr), 64'h60);
        next_cycle(); i_abort = 1'b0; @(negedge clk);
        chk("ab_g2_mreq", 64'(m_req), 64'd1);
        next_cycle(); @(negedge clk); chk("ab_g3_ihit", 64'(i_hit), 64'd0);
        next_cycle(); @(negedge clk); chk("ab_g4_madr", 64'(m_adr), 64'h60);
        next_cycle(); @(negedge clk);
        tmp = init_word(32);
        chk("ab_g5_ihit", 64'(i_hit), 64'd0);
        chk("ab_g5_mreq", 64'(m_req), 64'd0);
        chk("ab_g5_irdata", 64'(i_rdata), 64'(tmp[31:0]));
        next_cycle(); @(negedge clk);
        chk("ab_d_mreq", 64'(m_req), 64'd1);
        chk("ab_d_madr", 64'(m_adr), 64'h408);
        next_cycle(); next_cycle(); next_cycle(); next_cycle(); @(negedge clk);
        chk("ab_d_dready", 64'(d_ready), 64'd1);
        chk("ab_d_drdata", d_rdata, init_word(129));
        chk("ab_d_ihit", 64'(i_hit), 64'd0);
        next_cycle(); d_req = 1'b0; @(negedge clk);
        chk("ab_d_end", 64'(d_ready), 64'd0);
        next_cycle();

        // Asynchronous reset in the middle of a data access
        mem_lat = 4; d_req = 1'b1; d_we = 2'b11; d_adr = 32'h88; d_wdata = {$urandom, $urandom};
        next_cycle(); @(negedge clk); chk("rb_mreq", 64'(m_req), 64'd1);
        next_cycle(); #2 reset = 1'b1; #1;
        chk("rb_async_mreq", 64'(m_req), 64'd0);
        chk("rb_async_dready", 64'(d_ready), 64'd0);
        chk("rb_async_ihit", 64'(i_hit), 64'd0);
        d_req = 1'b0;
        next_cycle(); reset = 1'b0;
        mem_lat = 1; d_req = 1'b1; d_we = 2'b00; d_adr = 32'h410;
        next_cycle(); @(negedge clk);
        chk("rb_new_madr", 64'(m_adr), 64'h410);
        next_cycle(); @(negedge clk);
        chk("rb_new_dready", 64'(d_ready), 64'd1);
        chk("rb_new_drdata", d_rdata, init_word(130));
        next_cycle(); d_req = 1'b0;

        // Stray m_ack while idle is ignored
        stray_req++;
        next_cycle(); @(negedge clk);
        chk("st_mreq", 64'(m_req), 64'd0);
        chk("st_ihit", 64'(i_hit), 64'd0);
        chk("st_dready", 64'(d_ready), 64'd0);
        next_cycle(); @(negedge clk);
        chk("st_drdata", d_rdata, init_word(130));
        chk("st_dready2", 64'(d_ready), 64'd0);
        next_cycle();

`ifdef ARB_STATS_EN
        reset = 1'b1; next_cycle(); reset = 1'b0; next_cycle();
        do_txn(1'b1, 1'b0); do_txn(1'b1, 1'b0); do_txn(1'b1, 1'b1);
        do_txn(1'b0, 1'b0); do_txn(1'b0, 1'b0);
        stat_sel = 2'd0; #1 chk("stat_fetch", 64'(stat_out), 64'd3);
        stat_sel = 2'd1; #1 chk("stat_data", 64'(stat_out), 64'd2);
        stat_sel = 2'd2; #1 chk("stat_abort", 64'(stat_out), 64'd1);
        next_cycle();
`endif

        // Randomized traffic against the cycle-timeline reference
        reset = 1'b1; next_cycle(); next_cycle(); reset = 1'b0;
        busy = 1'b0; mcnt = 0; done = 0; g = 0; lat = 1; who_f = 1'b0;
        f_act = 1'b0; d_act = 1'b0; f_gap = 1; d_gap = 0;
        f_adr = '0; d_adr_r = '0; d_we_r = '0; d_wd_r = '0;
        cur_adr = '0; cur_we = '0; cur_wd = '0; cur_rd = '0;
        for (int c = 0; c < 4000 && done < 150; c++) begin
            i_req = f_act; i_adr = f_adr;
            d_req = d_act; d_adr = d_adr_r; d_we = d_we_r; d_wdata = d_wd_r;
            @(negedge clk);
            exp_mreq = busy && (c >= g + 1) && (c <= g + lat);
            pulse    = busy && (c == g + lat + 1);
            chk("rnd_mreq", 64'(m_req), 64'(exp_mreq));
            chk("rnd_ihit", 64'(i_hit), 64'(pulse && who_f));
            chk("rnd_dready", 64'(d_ready), 64'(pulse && !who_f));
            if (exp_mreq) begin
                chk("rnd_madr", 64'(m_adr), 64'(cur_adr));
                chk("rnd_mwe", 64'(m_we), 64'(cur_we));
                if (cur_we != 2'b00) chk("rnd_mwdata", m_wdata, cur_wd);
            end
            if (pulse) begin
                if (who_f) chk("rnd_irdata", 64'(i_rdata), 64'(cur_rd[31:0]));
                else chk("rnd_drdata", d_rdata, cur_rd);
                done++;
            end
            gf = 1'b0; gd = 1'b0;
            if (!busy || (c >= g + lat + 2)) begin
                busy = 1'b0;
                if (f_act && mcnt == STARVE) gf = 1'b1;
                else if (d_act) gd = 1'b1;
                else if (f_act) gf = 1'b1;
            end
            if (gf || gd) begin
                busy = 1'b1; g = c; lat = $urandom_range(1, 3); mem_lat = lat;
                who_f   = gf;
                cur_adr = gf ? f_adr : d_adr_r;
                cur_we  = gf ? 2'b00 : d_we_r;
                cur_wd  = d_wd_r;
                tmp = smem[cur_adr[10:3]];
                if (cur_we[0]) tmp[31:0]  = cur_wd[31:0];
                if (cur_we[1]) tmp[63:32] = cur_wd[63:32];
                smem[cur_adr[10:3]] = tmp;
                cur_rd = tmp;
            end
            if (!f_act || gf) mcnt = 0;
            else if (gd && mcnt < STARVE) mcnt++;
            if (pulse && who_f) begin
                f_act = 1'b0; f_gap = $urandom_range(1, 3);
            end else if (!f_act) begin
                if (f_gap > 0) f_gap--;
                else if ($urandom_range(0, 3) != 0) begin
                    f_act = 1'b1; f_adr = 32'($urandom_range(128, 255)) << 3;
                end
            end
            if ((pulse && !who_f) || (!d_act && d_gap == 0)) begin
                if (pulse && !who_f) d_gap = $urandom_range(0, 1);
                if (d_gap == 0 && $urandom_range(0, 2) != 0) begin
                    d_act = 1'b1; d_we_r = 2'($urandom_range(0, 3));
                    d_adr_r = 32'($urandom_range(128, 255)) << 3;
                    d_wd_r = {$urandom, $urandom};
                end else begin
                    d_act = 1'b0;
                end
            end else if (!d_act) begin
                d_gap--;
            end
            @(posedge clk); #1;
        end
        chk("rnd_txn_count", 64'(done >= 150), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
